// File: rtl/calc_pkg.sv
// Shared opcode encodings and FSM state type for the sequential calculator ALU.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Unsigned magnitude engine: shift-add multiply / restoring divide, one bit per cycle.
// prod/quot/rem show the value after the current iteration, so the caller can register them on last.
module alu_muldiv_iter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 op,
  input  logic [WIDTH-1:0]     mag_a,
  input  logic [WIDTH-1:0]     mag_b,
  output logic                 busy,
  output logic                 last,
  output logic [2*WIDTH-1:0]   prod,
  output logic [WIDTH-1:0]     quot,
  output logic [WIDTH-1:0]     rem
);

  localparam int CW = $clog2(WIDTH);

  logic               busy_q, busy_d;
  logic               op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     r_shift;
  logic [WIDTH:0]     r_sub;

  // op=0 multiply: mcand = shifted multiplicand, mplier = multiplier, acc = product.
  // op=1 divide:   mcand[W-1:0] = divisor, mplier = dividend shifting into quotient, acc = remainder.
  assign r_shift = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
  assign r_sub   = r_shift - {1'b0, mcand_q[WIDTH-1:0]};
  assign last    = busy_q && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    busy_d   = busy_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start) begin
      busy_d   = 1'b1;
      op_d     = op;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = op ? {{WIDTH{1'b0}}, mag_b} : {{WIDTH{1'b0}}, mag_a};
      mplier_d = op ? mag_a : mag_b;
    end else if (busy_q) begin
      if (!op_q) begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end else if (!r_sub[WIDTH]) begin
        acc_d    = {{WIDTH{1'b0}}, r_sub[WIDTH-1:0]};
        mplier_d = {mplier_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d    = {{WIDTH{1'b0}}, r_shift[WIDTH-1:0]};
        mplier_d = {mplier_q[WIDTH-2:0], 1'b0};
      end
      if (last) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      op_q     <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign busy = busy_q;
  assign prod = acc_d;
  assign quot = mplier_d;
  assign rem  = acc_d[WIDTH-1:0];

endmodule

// File: rtl/calc_alu_seq.sv
// Handshaked signed add/sub/mul/div; add/sub/div-by-zero complete next cycle, mul/div after WIDTH iterations.
// Sign handling, FSM and registered outputs live here; the magnitude engine is alu_muldiv_iter.
module calc_alu_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           opcode,
  input  logic [WIDTH-1:0]     data_a,
  input  logic [WIDTH-1:0]     data_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 err,
  output logic                 ovf
);

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic               sign_a_q, sign_a_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               err_q, err_d;
  logic               ovf_q, ovf_d;

  logic               accept;
  logic               start;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] sext_a, sext_b;
  logic               eng_busy, eng_last;
  logic [2*WIDTH-1:0] eng_prod;
  logic [WIDTH-1:0]   eng_quot, eng_rem;
  logic [WIDTH-1:0]   quot_s, rem_s;

  assign accept = in_valid && (state_q == IDLE);
  assign start  = accept && ((opcode == OP_MUL) || ((opcode == OP_DIV) && (data_b != '0)));
  // Magnitude of -2^(W-1) wraps to 2^(W-1), which is still correct read as unsigned.
  assign mag_a  = data_a[WIDTH-1] ? -data_a : data_a;
  assign mag_b  = data_b[WIDTH-1] ? -data_b : data_b;
  assign sext_a = {{WIDTH{data_a[WIDTH-1]}}, data_a};
  assign sext_b = {{WIDTH{data_b[WIDTH-1]}}, data_b};

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (opcode[0]),
    .mag_a (mag_a),
    .mag_b (mag_b),
    .busy  (eng_busy),
    .last  (eng_last),
    .prod  (eng_prod),
    .quot  (eng_quot),
    .rem   (eng_rem)
  );

  assign quot_s = neg_q ? -eng_quot : eng_quot;
  assign rem_s  = sign_a_q ? -eng_rem : eng_rem;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    sign_a_d = sign_a_q;
    result_d = result_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d     = opcode;
          neg_d    = data_a[WIDTH-1] ^ data_b[WIDTH-1];
          sign_a_d = data_a[WIDTH-1];
          state_d  = BUSY;
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            result_d = (opcode == OP_ADD) ? sext_a + sext_b : sext_a - sext_b;
            err_d    = 1'b0;
            ovf_d    = 1'b0;
            state_d  = DONE;
          end else if (opcode == OP_DIV && data_b == '0) begin
            result_d = '0;
            err_d    = 1'b1;
            ovf_d    = 1'b0;
            state_d  = DONE;
          end
        end
      end
      BUSY: begin
        if (eng_last) begin
          state_d = DONE;
          err_d   = 1'b0;
          if (op_q == OP_MUL) begin
            result_d = neg_q ? -eng_prod : eng_prod;
            ovf_d    = 1'b0;
          end else begin
            result_d = {rem_s, quot_s};
            // A positive quotient of magnitude 2^(W-1) only arises from -2^(W-1) / -1.
            ovf_d    = !neg_q && eng_quot[WIDTH-1];
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      sign_a_q <= sign_a_d;
      result_q <= result_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign err       = err_q;
  assign ovf       = ovf_q;

endmodule
